inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter IMEM_BYTES, default 32, the size of the instruction-memory window in bytes; addresses >= IMEM_BYTES are out of bounds.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; deassertion is synchronised to clk outside this block.
REQ-005 pc_o  out  32  fetch address to instruction memory; a registered output.
REQ-006 instr_i  in  32  instruction word returned combinationally for pc_o in the same cycle.
REQ-007 stall_i  in  1  load-use hold request from hazard detection.
REQ-008 branch_taken_i  in  1  taken-branch redirect, resolved in ID.
REQ-009 branch_target_i  in  32  branch target byte address.
REQ-010 jump_i  in  1  jump redirect.
REQ-011 jump_target_i  in  32  jump target byte address.
REQ-012 if_id_instr_o  out  32  IF/ID instruction register.
REQ-013 if_id_pc4_o  out  32  IF/ID register holding the fetch PC+4.
REQ-014 if_id_valid_o  out  1  IF/ID contents are a real instruction; 0 means a bubble.
REQ-015 fetch_oob_o  out  1  sticky flag: a fetch was attempted out of bounds.
REQ-016 fetch_count_o  out  32  count of instructions loaded into IF/ID with valid=1.

Function
REQ-017 FSM states: BOOT, RUN, HOLD.
- BOOT is entered only from reset.
- At the first edge after reset release, BOOT->RUN with no capture and pc_o unchanged.
REQ-018 In RUN or HOLD, next-PC priority per edge is: branch_taken_i > jump_i > stall_i > sequential.
REQ-019 Redirect (branch or jump):
- pc_o <= target with bits [1:0] forced to 0.
- IF/ID instr <= 0, pc4 <= 0, valid <= 0 (one bubble).
- State <= RUN.
- Applies even when stall_i=1.
REQ-020 Stall (no redirect): pc_o, the IF/ID registers, and fetch_count_o all hold; state <= HOLD.
REQ-021 Sequential in RUN or HOLD (no redirect, stall_i=0):
- IF/ID instr <= instr_i, pc4 <= pc_o+4, valid <= 1.
- pc_o <= pc_o+4.
- State <= RUN.
REQ-022 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
REQ-023 Sequential capture with pc_o >= IMEM_BYTES:
- IF/ID instr <= 0, valid <= 0.
- fetch_oob_o <= 1, held until reset.
- pc_o still advances.
- A later redirect into the window resumes normal fetch.
REQ-024 fetch_count_o increments by 1 on each edge that loads valid=1, wrapping modulo 2^32.
REQ-025 Fetch latency: an instruction presented at pc_o in cycle N appears on if_id_instr_o after edge N+1.

Reset
REQ-026 Asserting reset low, at any time including mid-stall or mid-redirect, immediately forces:
- pc_o=RESET_PC, if_id_instr_o=0, if_id_pc4_o=0, if_id_valid_o=0;
- fetch_oob_o=0, fetch_count_o=0;
- state=BOOT.
REQ-027 While reset is low, all inputs are ignored.

Structure
REQ-028 A shared pipeline package holds:
- the FSM state typedef;
- the NOP encoding constant (32'h0000_0000);
- the instruction width constant (32).
REQ-029 One sub-module, if_id_reg, implements the IF/ID register with load, flush and hold controls; next-PC selection and the FSM stay in inst_fetch.

Verification
REQ-030 Boot and sequential fetch: release reset with memory word 0=32'h2001_0001 and word 1=32'h2023_0003 -> pc_o sequence 0,0,4,8; after the 2nd edge if_id_instr_o=32'h2001_0001, if_id_pc4_o=4, valid=1; after the 3rd edge 32'h2023_0003, pc4=8.
REQ-031 Stall: stall_i=1 for 2 cycles while pc_o=8 -> pc_o stays 8, IF/ID unchanged, fetch_count_o unchanged; fetch resumes at 8 the next cycle.
REQ-032 Branch during stall: pc_o=16, stall_i=1, branch_taken_i=1, branch_target_i=32'h0000_0006 -> next pc_o=4, if_id_valid_o=0, fetch_count_o unchanged.
REQ-033 Bounds: run sequentially from pc_o=28 with IMEM_BYTES=32 -> the capture at pc_o=32 gives valid=0 and fetch_oob_o=1; a subsequent jump_i=1 to target 0 gives a valid fetch of word 0, with fetch_oob_o still 1.
REQ-034 Wrap: branch to 32'hFFFF_FFFC, then one sequential edge -> pc_o=0.
REQ-035 Reset mid-operation: assert reset low between edges while pc_o=12 and valid=1 -> all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM states, the
// instruction width and the NOP encoding used for bubbles.
package inst_fetch_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Redirect targets are byte addresses; fetch is word-granular.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble, load captures a new
// fetch result, and with neither asserted the contents hold.
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc4_i,
    input  logic               valid_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc4_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc4_q;
    logic               valid_q;

    // Flush has priority over load so a redirect always leaves a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= valid_i;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, next-PC selection with
// branch > jump > stall > sequential priority, bounds checking of the
// instruction-memory window and a count of valid fetches.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_target_i,
    input  logic               jump_i,
    input  logic [31:0]        jump_target_i,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [31:0]        if_id_pc4_o,
    output logic               if_id_valid_o,
    output logic               fetch_oob_o,
    output logic [31:0]        fetch_count_o
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               oob_q, oob_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        pc_plus4;
    logic               ifid_load;
    logic               ifid_flush;
    logic [INSTR_W-1:0] cap_instr;
    logic               cap_valid;

    // Wraps naturally at 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    // State, PC, sticky out-of-bounds flag and fetch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            oob_q   <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            oob_q   <= oob_d;
            count_q <= count_d;
        end
    end

    // Next-state, next-PC and IF/ID control decisions.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        oob_d      = oob_q;
        count_d    = count_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        cap_instr  = instr_i;
        cap_valid  = 1'b1;
        case (state_q)
            ST_BOOT: begin
                // First edge after reset only arms the pipeline.
                state_d = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (branch_taken_i) begin
                    pc_d       = word_align(branch_target_i);
                    ifid_flush = 1'b1;
                    state_d    = ST_RUN;
                end else if (jump_i) begin
                    pc_d       = word_align(jump_target_i);
                    ifid_flush = 1'b1;
                    state_d    = ST_RUN;
                end else if (stall_i) begin
                    state_d = ST_HOLD;
                end else begin
                    pc_d      = pc_plus4;
                    state_d   = ST_RUN;
                    ifid_load = 1'b1;
                    if (pc_q >= IMEM_LIMIT) begin
                        // Outside the window: keep advancing but deliver a bubble.
                        cap_instr = NOP_INSTR;
                        cap_valid = 1'b0;
                        oob_d     = 1'b1;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (cap_instr),
        .pc4_i   (pc_plus4),
        .valid_i (cap_valid),
        .instr_o (if_id_instr_o),
        .pc4_o   (if_id_pc4_o),
        .valid_o (if_id_valid_o)
    );

    assign pc_o          = pc_q;
    assign fetch_oob_o   = oob_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scoreboard bench for inst_fetch: each step pushes the expected
// post-edge outputs, the edge is taken, and the front entry is compared.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic        fetch_oob_o;
    logic [31:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        oob;
        logic [31:0] cnt;
        logic        pc4_chk;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] mem [0:7];

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_o            (pc_o),
        .instr_i         (instr_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_valid_o   (if_id_valid_o),
        .fetch_oob_o     (fetch_oob_o),
        .fetch_count_o   (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: combinational read, garbage outside the window.
    always_comb begin
        instr_i = 32'hBAD0_BAD0;
        if (pc_o < 32'd32) instr_i = mem[pc_o[4:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] epc, input logic [31:0] einstr,
                        input logic [31:0] epc4, input logic ev, input logic eoob,
                        input logic [31:0] ecnt, input logic pc4_chk);
        exp_t e;
        e.tag = tag; e.pc = epc; e.instr = einstr; e.pc4 = epc4;
        e.valid = ev; e.oob = eoob; e.cnt = ecnt; e.pc4_chk = pc4_chk;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".pc"},    pc_o,                   e.pc);
            chk({e.tag, ".instr"}, if_id_instr_o,          e.instr);
            if (e.pc4_chk) chk({e.tag, ".pc4"}, if_id_pc4_o, e.pc4);
            chk({e.tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, e.valid});
            chk({e.tag, ".oob"},   {31'd0, fetch_oob_o},   {31'd0, e.oob});
            chk({e.tag, ".cnt"},   fetch_count_o,          e.cnt);
            $display("step %-10s pc=%h instr=%h pc4=%h v=%0d oob=%0d cnt=%0d",
                     e.tag, pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
                     fetch_oob_o, fetch_count_o);
        end
    endtask

    // Drive one cycle of inputs, record the expectation, take the edge, compare.
    task automatic step(input string tag, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic st,
                        input logic [31:0] epc, input logic [31:0] einstr,
                        input logic [31:0] epc4, input logic ev, input logic eoob,
                        input logic [31:0] ecnt, input logic pc4_chk);
        branch_taken_i  = br;
        branch_target_i = bt;
        jump_i          = jp;
        jump_target_i   = jt;
        stall_i         = st;
        push(tag, epc, einstr, epc4, ev, eoob, ecnt, pc4_chk);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h2001_0001;
        mem[1] = 32'h2023_0003;
        for (int k = 2; k < 8; k++) mem[k] = 32'hA000_0000 + 32'(k);

        // Reset held with a redirect request present: it must be ignored.
        reset = 1'b0;
        stall_i = 1'b0; jump_i = 1'b0; jump_target_i = 32'h0;
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_0040;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1);
        pop_compare();
        branch_taken_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        //    tag          br   bt            jp   jt            st    pc            instr          pc4    v    oob  cnt  pc4chk
        step("boot",       0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,         32'h0,  0, 0, 0, 1);
        step("seq0",       0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h2001_0001, 32'h4,  1, 0, 1, 1);
        step("seq1",       0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h2023_0003, 32'h8,  1, 0, 2, 1);
        step("stall1",     0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h2023_0003, 32'h8,  1, 0, 2, 1);
        step("stall2",     0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h2023_0003, 32'h8,  1, 0, 2, 1);
        step("resume",     0, 32'h0,        0, 32'h0,        0, 32'hC,        32'hA000_0002, 32'hC,  1, 0, 3, 1);
        step("seq3",       0, 32'h0,        0, 32'h0,        0, 32'h10,       32'hA000_0003, 32'h10, 1, 0, 4, 1);
        step("br_stall",   1, 32'h6,        0, 32'h0,        1, 32'h4,        32'h0,         32'h0,  0, 0, 4, 1);
        step("jmp28",      0, 32'h0,        1, 32'h1C,       0, 32'h1C,       32'h0,         32'h0,  0, 0, 4, 1);
        step("seq7",       0, 32'h0,        0, 32'h0,        0, 32'h20,       32'hA000_0007, 32'h20, 1, 0, 5, 1);
        step("oob",        0, 32'h0,        0, 32'h0,        0, 32'h24,       32'h0,         32'h0,  0, 1, 5, 0);
        step("jmp0",       0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,         32'h0,  0, 1, 5, 1);
        step("reentry",    0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h2001_0001, 32'h4,  1, 1, 6, 1);
        step("br_vs_jmp",  1, 32'hFFFF_FFFC,1, 32'h10,       0, 32'hFFFF_FFFC,32'h0,         32'h0,  0, 1, 6, 1);
        step("wrap",       0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,         32'h0,  0, 1, 6, 0);
        step("post_wrap",  0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h2001_0001, 32'h4,  1, 1, 7, 1);
        step("seq_a",      0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h2023_0003, 32'h8,  1, 1, 8, 1);
        step("seq_b",      0, 32'h0,        0, 32'h0,        0, 32'hC,        32'hA000_0002, 32'hC,  1, 1, 9, 1);

        // Asynchronous reset between edges with pc=12 and a valid IF/ID entry.
        #2;
        reset = 1'b0;
        push("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1);
        #1;
        pop_compare();
        @(negedge clk);
        reset = 1'b1;

        step("reboot",     0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,         32'h0,  0, 0, 0, 1);
        step("refetch",    0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h2001_0001, 32'h4,  1, 0, 1, 1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
